oam_scanner: RTL

- PPU-side initiator of the PPU read port on the memory map. Implements Mode 2 (OAM scan).
- On a start pulse, reads the Y and X bytes of all 40 OAM entries through the shared PPU address/data path.
- Selects up to 10 sprites that overlap the current scanline and holds them in an indexed buffer for the pixel fetcher.
- Drives ppu_oam_read_en during the scan so the memory map blocks CPU OAM access.

---
 rtl/ppu_pkg.sv | 28 ++
 rtl/sprite_slot_buffer.sv | 42 ++++
 rtl/oam_scanner.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types: OAM scan state encoding, sprite sizing constants and the
// sprite slot record handed from the OAM scanner to the sprite fetcher.
package ppu_pkg;

  localparam int unsigned OAM_ENTRIES  = 40;
  localparam int unsigned MAX_SPRITES  = 10;
  localparam int unsigned OAM_Y_OFFSET = 16;
  localparam int unsigned OBJ_H_SHORT  = 8;
  localparam int unsigned OBJ_H_TALL   = 16;
  localparam int unsigned OAM_IDX_W    = 6;
  localparam int unsigned SLOT_IDX_W   = 4;
  localparam int unsigned PPU_ADDR_W   = 13;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN_Y = 3'd1,
    SCAN_X = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } oam_scan_state_t;

  typedef struct packed {
    logic [OAM_IDX_W-1:0] oam_index;
    logic [7:0]           x;
    logic [3:0]           row;
  } sprite_slot_t;

endpackage

// File: rtl/sprite_slot_buffer.sv
// Per-line sprite buffer: appends matched sprites in arrival order up to
// MAX_SPRITES and exposes them through a combinational indexed read port.
module sprite_slot_buffer
  import ppu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  sprite_slot_t          wr_data,
  output logic [SLOT_IDX_W-1:0] count,
  input  logic [SLOT_IDX_W-1:0] rd_index,
  output sprite_slot_t          rd_data
);

  sprite_slot_t slots [MAX_SPRITES];

  // Writes beyond the sprite limit are silently dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int k = 0; k < int'(MAX_SPRITES); k++) slots[k] <= '0;
    end else if (clear) begin
      count <= '0;
      for (int k = 0; k < int'(MAX_SPRITES); k++) slots[k] <= '0;
    end else if (wr_en && (count < SLOT_IDX_W'(MAX_SPRITES))) begin
      for (int k = 0; k < int'(MAX_SPRITES); k++) begin
        if (count == SLOT_IDX_W'(k)) slots[k] <= wr_data;
      end
      count <= count + SLOT_IDX_W'(1);
    end
  end

  // Out-of-range indexes read as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < int'(MAX_SPRITES); k++) begin
      if (rd_index == SLOT_IDX_W'(k)) rd_data = slots[k];
    end
  end

endmodule

// File: rtl/oam_scanner.sv
// Mode 2 OAM scan: walks the Y/X bytes of every OAM entry over the PPU read
// port and collects the sprites that overlap the latched scanline.
module oam_scanner
  import ppu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  lcd_en,
  input  logic                  obj_tall,
  input  logic [7:0]            ly,
  input  logic [7:0]            ppu_data_in,
  output logic [PPU_ADDR_W-1:0] ppu_addr,
  output logic                  ppu_oam_read_en,
  output logic                  ppu_read_mode,
  output logic                  busy,
  output logic                  done,
  output logic [SLOT_IDX_W-1:0] sprite_count,
  input  logic [SLOT_IDX_W-1:0] rd_index,
  output logic [OAM_IDX_W-1:0]  rd_oam_index,
  output logic [7:0]            rd_x,
  output logic [3:0]            rd_row
);

  oam_scan_state_t       state, state_nxt;
  logic [OAM_IDX_W-1:0]  i_q, i_nxt;
  logic [7:0]            ly_q, y_q;
  logic                  tall_q;
  logic                  load, y_en, eval, clear;
  logic [PPU_ADDR_W-1:0] addr_nxt;
  logic                  reading_nxt;

  logic [8:0]            t_c, y9_c, h_c;
  logic                  hit_c;
  logic [OAM_IDX_W-1:0]  i_prev_c;
  sprite_slot_t          wr_slot_c, rd_slot_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      i_q             <= '0;
      ly_q            <= '0;
      tall_q          <= 1'b0;
      y_q             <= '0;
      ppu_addr        <= '0;
      ppu_oam_read_en <= 1'b0;
      ppu_read_mode   <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      i_q             <= i_nxt;
      if (load) begin
        ly_q   <= ly;
        tall_q <= obj_tall;
      end
      if (y_en) y_q <= ppu_data_in;
      ppu_addr        <= addr_nxt;
      ppu_oam_read_en <= reading_nxt;
      ppu_read_mode   <= !reading_nxt;
      busy            <= (state_nxt != IDLE);
      done            <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    load      = 1'b0;
    y_en      = 1'b0;
    eval      = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start && lcd_en) begin
          state_nxt = SCAN_Y;
          i_nxt     = '0;
          load      = 1'b1;
          clear     = 1'b1;
        end
      end
      // Data on this cycle is the X byte of the previous entry.
      SCAN_Y: begin
        eval      = (i_q != '0);
        state_nxt = SCAN_X;
      end
      SCAN_X: begin
        y_en = 1'b1;
        if (i_q < OAM_IDX_W'(OAM_ENTRIES - 1)) begin
          i_nxt     = i_q + OAM_IDX_W'(1);
          state_nxt = SCAN_Y;
        end else begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        eval      = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if ((state != IDLE) && !lcd_en) begin
      state_nxt = IDLE;
      clear     = 1'b1;
      eval      = 1'b0;
      y_en      = 1'b0;
    end

    reading_nxt = (state_nxt == SCAN_Y) || (state_nxt == SCAN_X) || (state_nxt == FLUSH);
    case (state_nxt)
      SCAN_Y:  addr_nxt = {5'b0, i_nxt, 2'b00};
      SCAN_X:  addr_nxt = {5'b0, i_nxt, 2'b01};
      FLUSH,
      DONE:    addr_nxt = ppu_addr;
      default: addr_nxt = '0;
    endcase
  end

  // Overlap test done in 9 bits so ly+16 cannot wrap.
  always_comb begin
    t_c      = 9'(ly_q) + 9'(OAM_Y_OFFSET);
    y9_c     = 9'(y_q);
    h_c      = tall_q ? 9'(OBJ_H_TALL) : 9'(OBJ_H_SHORT);
    hit_c    = (t_c >= y9_c) && (t_c < (y9_c + h_c));
    i_prev_c = (state == FLUSH) ? i_q : (i_q - OAM_IDX_W'(1));
    wr_slot_c.oam_index = i_prev_c;
    wr_slot_c.x         = ppu_data_in;
    wr_slot_c.row       = 4'(t_c - y9_c);
  end

  sprite_slot_buffer u_slot_buffer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .wr_en    (eval && hit_c),
    .wr_data  (wr_slot_c),
    .count    (sprite_count),
    .rd_index (rd_index),
    .rd_data  (rd_slot_c)
  );

  assign rd_oam_index = rd_slot_c.oam_index;
  assign rd_x         = rd_slot_c.x;
  assign rd_row       = rd_slot_c.row;

endmodule
